// File: rtl/reg_pkg.sv
// Shared write-back definitions: register-file geometry and the
// buffered write request bundle, also used by decode stall logic.
package reg_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req;

  function automatic logic [NUM_REGS-1:0] onehot(
    input logic [ADDR_W-1:0] a,
    input logic              en
  );
    onehot = {{(NUM_REGS-1){1'b0}}, en} << a;
  endfunction

endpackage

// File: rtl/wb_req_buf.sv
// One-entry write-back holding buffer with valid/ready handshake.
// An entry being granted this cycle can be replaced at the same edge.
module wb_req_buf
  import reg_pkg::*;
(
  input  logic              regi_clk,
  input  logic              regi_rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  output logic              o_ready,
  output logic              o_load,
  output wb_req             o_buf
);

  wb_req r_buf;
  logic  w_ready;
  logic  w_load;

  assign w_ready = !r_buf.v | i_grant;
  assign w_load  = i_valid & w_ready;

  always_ff @(posedge regi_clk or negedge regi_rst) begin
    if (!regi_rst) begin
      r_buf <= '0;
    end else if (w_load) begin
      r_buf.v    <= 1'b1;
      r_buf.addr <= i_addr;
      r_buf.data <= i_data;
    end else if (i_grant) begin
      r_buf.v <= 1'b0;
    end
  end

  assign o_ready = w_ready;
  assign o_load  = w_load;
  assign o_buf   = r_buf;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Age-ordered arbiter sharing the register-file write port between
// the execute (req0) and memory-load (req1) write-back requesters.
module reg_wb_arbiter
  import reg_pkg::*;
(
  input  logic                regi_clk,
  input  logic                regi_rst,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  output logic                wb_wrn,
  output logic [ADDR_W-1:0]   wb_waddr,
  output logic [DATA_W-1:0]   wb_wdata,
  output logic [NUM_REGS-1:0] pend_mask
);

  wb_req             w_b0;
  wb_req             w_b1;
  logic              w_g0;
  logic              w_g1;
  logic              w_ld0;
  logic              w_ld1;
  logic              w_keep0;
  logic              w_keep1;
  logic              w_older_nxt;
  logic              r_older;
  logic              r_wrn;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  wb_req_buf u_buf0 (
    .regi_clk (regi_clk),
    .regi_rst (regi_rst),
    .i_valid  (req0_valid),
    .i_addr   (req0_addr),
    .i_data   (req0_data),
    .i_grant  (w_g0),
    .o_ready  (req0_ready),
    .o_load   (w_ld0),
    .o_buf    (w_b0)
  );

  wb_req_buf u_buf1 (
    .regi_clk (regi_clk),
    .regi_rst (regi_rst),
    .i_valid  (req1_valid),
    .i_addr   (req1_addr),
    .i_data   (req1_data),
    .i_grant  (w_g1),
    .o_ready  (req1_ready),
    .o_load   (w_ld1),
    .o_buf    (w_b1)
  );

  // r_older = 1 means buf1 holds the older entry
  assign w_g0 = w_b0.v & (!w_b1.v | !r_older);
  assign w_g1 = w_b1.v & (!w_b0.v | r_older);

  assign w_keep0 = w_b0.v & !w_g0;
  assign w_keep1 = w_b1.v & !w_g1;

  always_comb begin
    w_older_nxt = r_older;
    if (w_ld0 & w_ld1) begin
      w_older_nxt = 1'b1;
    end else if (w_ld0) begin
      w_older_nxt = w_keep1;
    end else if (w_ld1) begin
      w_older_nxt = !w_keep0;
    end else if (w_keep0 & !w_keep1) begin
      w_older_nxt = 1'b0;
    end else if (w_keep1 & !w_keep0) begin
      w_older_nxt = 1'b1;
    end
  end

  always_ff @(posedge regi_clk or negedge regi_rst) begin
    if (!regi_rst) begin
      r_older <= 1'b0;
      r_wrn   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_older <= w_older_nxt;
      r_wrn   <= w_g0 | w_g1;
      if (w_g1) begin
        r_waddr <= w_b1.addr;
        r_wdata <= w_b1.data;
      end else if (w_g0) begin
        r_waddr <= w_b0.addr;
        r_wdata <= w_b0.data;
      end
    end
  end

  assign wb_wrn   = r_wrn;
  assign wb_waddr = r_waddr;
  assign wb_wdata = r_wdata;

  assign pend_mask = onehot(w_b0.addr, w_b0.v)
                   | onehot(w_b1.addr, w_b1.v)
                   | onehot(r_waddr, r_wrn);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with an age-ordered queue model
// checked every cycle plus literal expectations.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic [3:0]  req0_addr;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [3:0]  req1_addr;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        wb_wrn;
  logic [3:0]  wb_waddr;
  logic [15:0] wb_wdata;
  logic [15:0] pend_mask;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .regi_clk   (clk),
    .regi_rst   (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wb_wrn     (wb_wrn),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .pend_mask  (pend_mask)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: pending writes in age order (oldest first) plus the port
  typedef struct {
    int          src;
    logic [3:0]  addr;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  ent_t        me;
  logic        m_wrn;
  logic [3:0]  m_waddr;
  logic [15:0] m_wdata;
  logic        ma0;
  logic        ma1;

  function automatic logic m_ready(input int s);
    if (mq.size() == 0) return 1'b1;
    if (mq[0].src == s) return 1'b1;
    foreach (mq[i]) if (mq[i].src == s) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_pend();
    logic [15:0] p;
    p = '0;
    foreach (mq[i]) p[mq[i].addr] = 1'b1;
    if (m_wrn) p[m_waddr] = 1'b1;
    return p;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_wrn   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      ma0 = req0_valid && m_ready(0);
      ma1 = req1_valid && m_ready(1);
      if (mq.size() > 0) begin
        me      = mq.pop_front();
        m_wrn   = 1'b1;
        m_waddr = me.addr;
        m_wdata = me.data;
      end else begin
        m_wrn = 1'b0;
      end
      if (ma1) mq.push_back('{1, req1_addr, req1_data});
      if (ma0) mq.push_back('{0, req0_addr, req0_data});
    end
  end

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("m_ready0", 32'(req0_ready), 32'(m_ready(0)));
      chk("m_ready1", 32'(req1_ready), 32'(m_ready(1)));
      chk("m_wrn", 32'(wb_wrn), 32'(m_wrn));
      chk("m_waddr", 32'(wb_waddr), 32'(m_waddr));
      chk("m_wdata", 32'(wb_wdata), 32'(m_wdata));
      chk("m_pend", 32'(pend_mask), 32'(m_pend()));
    end
  end

  // Register file and commit log fed by the write port
  logic [15:0] rf [16];
  logic [19:0] clog[$];

  always @(posedge clk) begin
    if (rst && wb_wrn) begin
      rf[wb_waddr] = wb_wdata;
      clog.push_back({wb_waddr, wb_wdata});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int n0;
  int n1;
  int cnt[16];
  bit acc0;
  bit acc1;

  initial begin
    rst        = 1'b0;
    req0_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_addr  = '0;
    req1_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wrn", 32'(wb_wrn), 32'd0);
    chk("rst_waddr", 32'(wb_waddr), 32'd0);
    chk("rst_wdata", 32'(wb_wdata), 32'd0);
    chk("rst_pend", 32'(pend_mask), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd1);
    chk("rst_rdy1", 32'(req1_ready), 32'd1);
    @(negedge clk);
    rst    = 1'b1;
    cmp_en = 1'b1;
    cyc();

    // single write latency
    req0_valid = 1'b1;
    req0_addr  = 4'd3;
    req0_data  = 16'h1234;
    cyc();
    req0_valid = 1'b0;
    chk("lat_pend_k", 32'(pend_mask), 32'h0008);
    chk("lat_wrn_k", 32'(wb_wrn), 32'd0);
    cyc();
    chk("lat_wrn_k1", 32'(wb_wrn), 32'd1);
    chk("lat_addr_k1", 32'(wb_waddr), 32'd3);
    chk("lat_data_k1", 32'(wb_wdata), 32'h1234);
    chk("lat_pend_k1", 32'(pend_mask), 32'h0008);
    cyc();
    chk("lat_wrn_k2", 32'(wb_wrn), 32'd0);
    chk("lat_pend_k2", 32'(pend_mask), 32'd0);
    chk("lat_hold", 32'(wb_waddr), 32'd3);

    // simultaneous same-address requests
    req0_valid = 1'b1;
    req0_addr  = 4'd5;
    req0_data  = 16'hAAAA;
    req1_valid = 1'b1;
    req1_addr  = 4'd5;
    req1_data  = 16'hBBBB;
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("sim_pend", 32'(pend_mask), 32'h0020);
    cyc();
    chk("sim_wrn1", 32'(wb_wrn), 32'd1);
    chk("sim_addr1", 32'(wb_waddr), 32'd5);
    chk("sim_data1", 32'(wb_wdata), 32'hBBBB);
    cyc();
    chk("sim_data2", 32'(wb_wdata), 32'hAAAA);
    cyc();
    chk("sim_wrn3", 32'(wb_wrn), 32'd0);
    chk("sim_r5", 32'(rf[5]), 32'hAAAA);

    // age ordering: req1 first, req0 one cycle later
    req1_valid = 1'b1;
    req1_addr  = 4'd7;
    req1_data  = 16'h0001;
    cyc();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = 4'd7;
    req0_data  = 16'h0002;
    chk("age_pend0", 32'(pend_mask), 32'h0080);
    cyc();
    req0_valid = 1'b0;
    chk("age_data1", 32'(wb_wdata), 32'h0001);
    chk("age_pend1", 32'(pend_mask[7]), 32'd1);
    cyc();
    chk("age_data2", 32'(wb_wdata), 32'h0002);
    chk("age_wrn2", 32'(wb_wrn), 32'd1);
    chk("age_pend2", 32'(pend_mask[7]), 32'd1);
    cyc();
    chk("age_wrn3", 32'(wb_wrn), 32'd0);
    chk("age_pend3", 32'(pend_mask), 32'd0);

    // contention: both requesters stream for 8 cycles
    clog.delete();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1;
      req0_addr  = 4'(n0);
      req0_data  = 16'(16'h0A00 + n0);
      req1_valid = 1'b1;
      req1_addr  = 4'(8 + n1);
      req1_data  = 16'(16'h0B00 + n1);
      @(negedge clk);
      acc0 = req0_ready;
      acc1 = req1_ready;
      if (i >= 1) begin
        chk("ct_rdy1", 32'(req1_ready), 32'(i % 2));
        chk("ct_rdy0", 32'(req0_ready), 32'((i + 1) % 2));
      end
      if (i >= 2) chk("ct_wrn", 32'(wb_wrn), 32'd1);
      cyc();
      if (acc0) n0++;
      if (acc1) n1++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) cyc();
    chk("sb_accepted", 32'(n0 + n1), 32'd9);
    chk("sb_total", 32'(clog.size()), 32'(n0 + n1));
    foreach (cnt[a]) cnt[a] = 0;
    foreach (clog[i]) begin
      cnt[clog[i][19:16]]++;
      if (clog[i][19:16] < 4'd8)
        chk("sb_data0", 32'(clog[i][15:0]),
            32'(16'h0A00 + clog[i][19:16]));
      else
        chk("sb_data1", 32'(clog[i][15:0]),
            32'(16'h0B00 + clog[i][19:16] - 8));
    end
    for (int a = 0; a < 16; a++)
      chk("sb_once", 32'(cnt[a]),
          (a < 8) ? 32'(a < n0) : 32'((a - 8) < n1));

    // single requester streaming
    clog.delete();
    for (int i = 1; i <= 4; i++) begin
      req0_valid = 1'b1;
      req0_addr  = 4'(i);
      req0_data  = 16'(16'h0C00 + i);
      @(negedge clk);
      chk("st_rdy0", 32'(req0_ready), 32'd1);
      cyc();
    end
    req0_valid = 1'b0;
    repeat (3) cyc();
    chk("st_count", 32'(clog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < clog.size())
        chk("st_order", 32'(clog[i]),
            32'({4'(i + 1), 16'(16'h0C01 + i)}));

    // asynchronous reset mid-stream
    req0_valid = 1'b1;
    req0_addr  = 4'd9;
    req0_data  = 16'h9999;
    req1_valid = 1'b1;
    req1_addr  = 4'd10;
    req1_data  = 16'hA0A0;
    cyc();
    cyc();
    chk("mr_wrn_pre", 32'(wb_wrn), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_wrn", 32'(wb_wrn), 32'd0);
    chk("mr_pend", 32'(pend_mask), 32'd0);
    chk("mr_rdy0", 32'(req0_ready), 32'd1);
    chk("mr_rdy1", 32'(req1_ready), 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    cyc();
    chk("mr_after", 32'(wb_wrn), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single register-file write port (wrn/waddr/wdata) between two write-back requesters: req0 = ALU/execute result, req1 = memory-load result.
- Each requester gets a one-entry holding buffer with a valid/ready handshake.
- An age-ordered arbiter drains the buffers into a registered write-port output, at most one write per cycle.
- Exports a 16-bit pending-write mask so decode can stall reads of registers with uncommitted writes.

Parameters:
- ADDR_W, 4, register address width.
- DATA_W, 16, register data width.
- NUM_REGS, 16, number of architectural registers; equals 2**ADDR_W and sets the pend_mask width.

Ports:
- regi_clk  in  1  clock; all state updates on rising edge.
- regi_rst  in  1  asynchronous reset, active-low.
- req0_valid  in  1  requester 0 has a write.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 buffer can accept this cycle.
- req1_valid  in  1  requester 1 has a write.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- req1_ready  out  1  requester 1 buffer can accept this cycle.
- wb_wrn  out  1  register-file write enable (1 = write).
- wb_waddr  out  ADDR_W  register-file write address.
- wb_wdata  out  DATA_W  register-file write data.
- pend_mask  out  NUM_REGS  bit i = 1 while any write to register i is buffered or sitting on the write port.

Behaviour:
- Reset (regi_rst=0, asynchronous): both buffers invalid, age flag = 0, wb_wrn=0, wb_waddr=0, wb_wdata=0, pend_mask=0. With both buffers empty, req0_ready=req1_ready=1.
- Buffers: each holds v/addr/data.
  - Accept when reqN_valid & reqN_ready; the buffer is loaded at that edge.
  - reqN_ready = !bufN.v | grantN (combinational), so an entry being granted this cycle can be replaced at the same edge.
  - Each requester can therefore sustain one request per cycle when it is uncontested.
- Age flag ("older"):
  - Loaded into an empty pair: the loaded buffer is older.
  - Both loaded into an empty pair on the same edge: buf1 is older, because the memory stage carries the older instruction.
  - A buffer loaded while the other stays valid is younger.
  - When the older entry drains and the remaining one stays valid, the remaining one becomes older.
- Grant (combinational, registers only):
  - Only buf0 valid: grant0.
  - Only buf1 valid: grant1.
  - Both valid: grant the older entry.
  - Neither valid: no grant.
  - This preserves program order for same-address writes and guarantees no starvation: a waiting entry wins within one cycle.
- Write port register, updated each edge:
  - wb_wrn <= grant0 | grant1.
  - On a grant, wb_waddr/wb_wdata <= the granted buffer's addr/data.
  - With no grant, wb_waddr/wb_wdata hold their previous values and only wb_wrn drops.
- Latency: accept at edge k → earliest grant in cycle k..k+1 → wb_wrn=1 after edge k+1 → register file written at edge k+2.
- Throughput: one committed write per cycle in total. When both requesters stream, each sees ready=0 on alternate cycles.
- pend_mask: combinational OR of one-hot(buf0.addr)&buf0.v, one-hot(buf1.addr)&buf1.v, and one-hot(wb_waddr)&wb_wrn.
- Same-address entries in both buffers: older written first, younger the next cycle. The final register value is the younger entry's data.
- Address 0 has no special treatment; writes to it are committed like any other.
- Reset mid-operation: buffered and in-flight writes are discarded. wb_wrn drops immediately (asynchronously), so no partial write occurs after reset assertion.
- Data and addr inputs are ignored unless valid & ready.

Decomposition:
- Shared package reg_pkg: ADDR_W, DATA_W, NUM_REGS constants and a wb_req typedef {v, addr, data}. The package is reused by decode stall logic.
- One natural sub-module: wb_req_buf, the one-entry holding buffer with ready logic, instantiated twice.
- Arbiter, age flag, output register and pend_mask logic stay in the top module.

Test Plan:
- Reset values: hold regi_rst=0 → wb_wrn=0, wb_waddr=0, wb_wdata=0, pend_mask=0, req0_ready=req1_ready=1. Assert reset mid-stream → wb_wrn falls without waiting for a clock edge.
- Single write latency: req0 addr=3 data=0x1234 accepted at edge k → pend_mask=0x0008 after k. After edge k+1: wb_wrn=1, wb_waddr=3, wb_wdata=0x1234. After edge k+2: wb_wrn=0 and pend_mask=0.
- Simultaneous requests: req0 (5,0xAAAA) and req1 (5,0xBBBB) accepted on the same edge → wb_waddr=5/0xBBBB on one cycle, then 5/0xAAAA on the next. A reg_file model ends with R5=0xAAAA.
- Age ordering: req1 (7,0x0001) buffered first; req0 (7,0x0002) arrives the next cycle → commits are 0x0001 then 0x0002. The pend_mask bit 7 stays set until the second commit is on the port, and clears the cycle after.
- Contention throughput: both valid every cycle for 8 cycles with distinct addresses → wb_wrn=1 every cycle, grants alternate 1,0,1,0…, each ready is 0 on alternate cycles, and no request is lost or duplicated (scoreboard check).
- Single-requester streaming: req0 valid for 4 consecutive cycles with addrs 1..4 and req1 idle → req0_ready stays 1, and four consecutive writes appear in order 1,2,3,4.
